// File: rtl/led_drv_n_pkg.sv
// Shared types for the N-channel LED driver: mode codes, burst FSM states, duty constants.
// The duty constants only matter when LED_DRV_PWM_EN is defined.
package led_drv_n_pkg;
   localparam int MODE_W = 2;
   localparam int DUTY_W = 4;
   localparam logic [DUTY_W-1:0] DUTY_RST = 4'hF;

   typedef enum logic [MODE_W-1:0] {
      M_OFF   = 2'd0,
      M_ON    = 2'd1,
      M_FLASH = 2'd2,
      M_BURST = 2'd3
   } mode_t;

   // WAIT = burst written but not armed yet; RUN = armed, counting falls
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RUN  = 2'd2
   } chn_state_t;
endpackage

// File: rtl/led_drv_n_if.sv
// Mode-write bus from the controller into the LED driver.
// LED_DRV_PWM_EN adds the per-write duty field.
interface led_drv_n_if #(parameter int CH_W = 3);
   import led_drv_n_pkg::*;

   // wr_vld is a strobe with no ready: every cycle it is high, the write is taken.
   logic              wr_vld;
   logic [CH_W-1:0]   wr_chn;
   logic [MODE_W-1:0] wr_mode;
`ifdef LED_DRV_PWM_EN
   logic [DUTY_W-1:0] wr_duty;

   modport master (output wr_vld, wr_chn, wr_mode, wr_duty);
   modport slave  (input  wr_vld, wr_chn, wr_mode, wr_duty);
`else
   modport master (output wr_vld, wr_chn, wr_mode);
   modport slave  (input  wr_vld, wr_chn, wr_mode);
`endif
endinterface

// File: rtl/led_drv_n_chn.sv
// One LED channel: mode register, burst FSM (IDLE/WAIT/RUN) and the unregistered drive value f.
// LED_DRV_PWM_EN adds a per-channel duty register gating f against the shared pwm counter.
module led_drv_n_chn
   import led_drv_n_pkg::*;
#(
   parameter int BURST_CNT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  mode_t             i_wr_mode,
`ifdef LED_DRV_PWM_EN
   input  logic [DUTY_W-1:0] i_wr_duty,
   input  logic [DUTY_W-1:0] i_pwm_cnt,
`endif
   input  logic              i_rise_t,
   input  logic              i_fall_t,
   input  logic              i_phase,
   output logic              o_f,
   output chn_state_t        o_state
);
   localparam int REM_W = $clog2(BURST_CNT + 1);

   mode_t            r_mode,  w_mode_nxt;
   chn_state_t       r_state, w_state_nxt;
   logic [REM_W-1:0] r_rem,   w_rem_nxt;
   logic             w_f;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode  <= M_OFF;
         r_state <= S_IDLE;
         r_rem   <= '0;
      end else begin
         r_mode  <= w_mode_nxt;
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // A write always beats a same-cycle rise/fall, so arming never happens on the write edge.
   always_comb begin
      w_mode_nxt  = r_mode;
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      if (i_we) begin
         w_mode_nxt = i_wr_mode;
         if (i_wr_mode == M_BURST) begin
            w_state_nxt = S_WAIT;
            w_rem_nxt   = REM_W'(BURST_CNT);
         end else begin
            w_state_nxt = S_IDLE;
         end
      end else begin
         case (r_state)
            S_WAIT: if (i_rise_t) w_state_nxt = S_RUN;
            S_RUN: begin
               if (i_fall_t) begin
                  w_rem_nxt = r_rem - REM_W'(1);
                  if (r_rem == REM_W'(1)) begin
                     w_mode_nxt  = M_OFF;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_f = 1'b0;
      case (r_mode)
         M_ON:    w_f = 1'b1;
         M_FLASH: w_f = i_phase;
         M_BURST: w_f = i_phase & (r_state == S_RUN);
         default: w_f = 1'b0;
      endcase
   end

`ifdef LED_DRV_PWM_EN
   logic [DUTY_W-1:0] r_duty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_duty <= DUTY_RST;
      else if (i_we) r_duty <= i_wr_duty;
   end

   assign o_f = w_f & (i_pwm_cnt < r_duty);
`else
   assign o_f = w_f;
`endif

   assign o_state = r_state;
endmodule

// File: rtl/led_drv_n.sv
// N-channel panel LED driver top: shared flash prescaler, write decode, registered led/busy pins.
// LED_DRV_PWM_EN enables per-channel duty dimming via a free-running 4-bit pwm counter.
module led_drv_n
   import led_drv_n_pkg::*;
#(
   parameter int N_CH      = 6,
   parameter int DIV       = 25_000_000,
   parameter int DIV_W     = 25,
   parameter int BURST_CNT = 3,
   parameter int CH_W      = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   led_drv_n_if.slave      bus,
   output logic [N_CH-1:0] led,
   output logic [N_CH-1:0] busy
);
   logic [DIV_W-1:0] r_cnt;
   logic             r_phase;
   logic             w_tick, w_rise_t, w_fall_t;
   logic [N_CH-1:0]  w_we, w_f, w_busy;
   logic [N_CH-1:0]  r_led, r_busy;

   // Free-running regardless of en so FLASH channels resume in lockstep with the timebase.
   assign w_tick   = (r_cnt == DIV_W'(DIV - 1));
   assign w_rise_t = w_tick & ~r_phase;
   assign w_fall_t = w_tick &  r_phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_phase <= 1'b0;
      end else if (w_tick) begin
         r_cnt   <= '0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + DIV_W'(1);
      end
   end

`ifdef LED_DRV_PWM_EN
   logic [DUTY_W-1:0] r_pwm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pwm_cnt <= '0;
      else     r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
   end
`endif

   for (genvar i = 0; i < N_CH; i++) begin : g_chn
      chn_state_t w_state;

      // Channel indices >= N_CH match no instance, so such writes fall away.
      assign w_we[i] = bus.wr_vld && (bus.wr_chn == CH_W'(i));

      led_drv_n_chn #(.BURST_CNT(BURST_CNT)) u_chn (
         .clk       (clk),
         .rst       (rst),
         .i_we      (w_we[i]),
         .i_wr_mode (mode_t'(bus.wr_mode)),
`ifdef LED_DRV_PWM_EN
         .i_wr_duty (bus.wr_duty),
         .i_pwm_cnt (r_pwm_cnt),
`endif
         .i_rise_t  (w_rise_t),
         .i_fall_t  (w_fall_t),
         .i_phase   (r_phase),
         .o_f       (w_f[i]),
         .o_state   (w_state)
      );

      assign w_busy[i] = (w_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led  <= '0;
         r_busy <= '0;
      end else begin
         r_led  <= {N_CH{en}} & w_f;
         r_busy <= w_busy;
      end
   end

   assign led  = r_led;
   assign busy = r_busy;
endmodule

// File: tb/tb_led_drv_n.sv
// Bench for led_drv_n: reset checks, a constant vector table, hand burst sequences and
// random writes scored against a cycle-count based model. LED_DRV_PWM_EN adds the duty test.
module tb_led_drv_n;
   localparam int N_CH      = 3;
   localparam int DIV       = 4;
   localparam int DIV_W     = 3;
   localparam int BURST_CNT = 2;
   localparam int CH_W      = 3;
   localparam int W         = 2 * N_CH;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [N_CH-1:0] led, busy;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];

   led_drv_n_if #(.CH_W(CH_W)) bus();

   led_drv_n #(
      .N_CH(N_CH), .DIV(DIV), .DIV_W(DIV_W), .BURST_CNT(BURST_CNT), .CH_W(CH_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .bus  (bus),
      .led  (led),
      .busy (busy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Time is the number of clock edges since reset release; the flash phase and the
   // rise/fall instants follow directly from it by division.
   int m_n;
   int m_mode[N_CH];
   int m_rem[N_CH];
   int m_armed[N_CH];
   int m_duty[N_CH];

   task automatic model_reset();
      m_n = 0;
      for (int i = 0; i < N_CH; i++) begin
         m_mode[i]  = 0;
         m_rem[i]   = 0;
         m_armed[i] = 0;
         m_duty[i]  = 15;
      end
   endtask

   task automatic model_edge(output logic [W-1:0] exp_v);
      int ph;
      int tick;
      int f;
      logic [N_CH-1:0] l, b;
      ph   = (m_n / DIV) % 2;
      tick = ((m_n % DIV) == DIV - 1) ? 1 : 0;
      for (int i = 0; i < N_CH; i++) begin
         case (m_mode[i])
            1:       f = 1;
            2:       f = ph;
            3:       f = ph & m_armed[i];
            default: f = 0;
         endcase
`ifdef LED_DRV_PWM_EN
         if ((m_n % 16) >= m_duty[i]) f = 0;
`endif
         l[i] = en & (f != 0);
         b[i] = (m_mode[i] == 3);
      end
      exp_v = {l, b};
      for (int i = 0; i < N_CH; i++) begin
         if (bus.wr_vld && int'(bus.wr_chn) == i) begin
            m_mode[i]  = int'(bus.wr_mode);
            m_armed[i] = 0;
            if (m_mode[i] == 3) m_rem[i] = BURST_CNT;
`ifdef LED_DRV_PWM_EN
            m_duty[i] = int'(bus.wr_duty);
`endif
         end else if (m_mode[i] == 3 && tick == 1) begin
            if (ph == 0) begin
               m_armed[i] = 1;
            end else if (m_armed[i] == 1) begin
               m_rem[i] = m_rem[i] - 1;
               if (m_rem[i] == 0) begin
                  m_mode[i]  = 0;
                  m_armed[i] = 0;
               end
            end
         end
      end
      m_n = m_n + 1;
   endtask

   // ---------------- checks ----------------
   task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual led/busy=%b required=%b at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit vld, input int chn, input int mode, input int duty);
      bus.wr_vld  = vld;
      bus.wr_chn  = CH_W'(chn);
      bus.wr_mode = 2'(mode);
`ifdef LED_DRV_PWM_EN
      bus.wr_duty = 4'(duty);
`else
      if (duty < 0) $display("note: negative duty ignored");
`endif
   endtask

   // One clock edge: the model predicts, the scoreboard compares #1 after the edge.
   task automatic step(input string name, output logic [W-1:0] act);
      logic [W-1:0] e;
      model_edge(e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      act = {led, busy};
      check_vec(name, act, exp_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 15);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      exp_q.delete();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit              vld;
      int              chn;
      int              mode;
      bit              en;
      int              n;
      logic [N_CH-1:0] led;
      logic [N_CH-1:0] busy;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [W-1:0] a;
      int c1, c2, c3, c4;

      rst = 1'b1;
      en  = 1'b1;
      drive(0, 0, 0, 15);
      model_reset();

      // Write ON ch0, FLASH ch1, BURST ch2 while phase=1, then en and invalid-channel rows.
      vecs[0]  = '{1'b1, 0, 1, 1'b1, 1, 3'b000, 3'b000};
      vecs[1]  = '{1'b1, 1, 2, 1'b1, 3, 3'b001, 3'b000};
      vecs[2]  = '{1'b0, 0, 0, 1'b1, 1, 3'b011, 3'b000};
      vecs[3]  = '{1'b1, 2, 3, 1'b1, 1, 3'b011, 3'b000};
      vecs[4]  = '{1'b0, 0, 0, 1'b1, 2, 3'b011, 3'b100};
      vecs[5]  = '{1'b0, 0, 0, 1'b1, 4, 3'b001, 3'b100};
      vecs[6]  = '{1'b0, 0, 0, 1'b1, 4, 3'b111, 3'b100};
      vecs[7]  = '{1'b0, 0, 0, 1'b1, 4, 3'b001, 3'b100};
      vecs[8]  = '{1'b0, 0, 0, 1'b1, 4, 3'b111, 3'b100};
      vecs[9]  = '{1'b0, 0, 0, 1'b1, 4, 3'b001, 3'b000};
      vecs[10] = '{1'b0, 0, 0, 1'b1, 4, 3'b011, 3'b000};
      vecs[11] = '{1'b0, 0, 0, 1'b0, 4, 3'b000, 3'b000};
      vecs[12] = '{1'b0, 0, 0, 1'b1, 4, 3'b011, 3'b000};
      vecs[13] = '{1'b1, 3, 1, 1'b1, 1, 3'b001, 3'b000};
      vecs[14] = '{1'b1, 7, 2, 1'b1, 3, 3'b001, 3'b000};
      vecs[15] = '{1'b0, 0, 0, 1'b1, 4, 3'b011, 3'b000};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_vec("reset_state", {led, busy}, '0);
      @(negedge clk);
      rst = 1'b0;

      // idle after reset: nothing lights
      c1 = 0;
      for (int c = 0; c < 50; c++) begin
         step("idle", a);
         if (a != '0) c1++;
      end
      check_int("idle_lit_cycles", c1, 0);

      // async reset mid-cycle clears a lit output before the next edge
      drive(1, 0, 1, 15);
      step("pre_areset", a);
      drive(0, 0, 0, 15);
      step("pre_areset", a);
      check_vec("lit_before_areset", a, {3'b001, 3'b000});
      #3;
      rst = 1'b1;
      #1;
      check_vec("async_reset_clear", {led, busy}, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();

      // table
      for (int r = 0; r < 16; r++) begin
         for (int k = 0; k < vecs[r].n; k++) begin
            en = vecs[r].en;
            drive(vecs[r].vld && k == 0, vecs[r].chn, vecs[r].mode, 15);
            step("vec_model", a);
            check_vec($sformatf("vec%0d_cyc%0d", r, k), a, {vecs[r].led, vecs[r].busy});
         end
      end
      drive(0, 0, 0, 15);
      en = 1'b1;

      // burst restart, OFF on the completing fall, BURST written on a rise
      do_reset();
      c1 = 0; c2 = 0; c3 = 0; c4 = 0;
      for (int e = 1; e <= 56; e++) begin
         if (e == 1 || e == 9 || e == 28) drive(1, 2, 3, 15);
         else if (e == 24)                drive(1, 2, 0, 15);
         else                             drive(0, 0, 0, 15);
         step("burst_seq", a);
         if (a[N_CH + 2]) begin
            if (e <= 24)      c1++;
            else if (e <= 36) c2++;
            else if (e <= 48) c3++;
            else              c4++;
         end
         if (e == 25) check_int("busy_after_off_on_fall", int'(a[2]), 0);
         if (e == 48) check_int("busy_last_fall", int'(a[2]), 1);
         if (e == 49) check_int("busy_after_done", int'(a[2]), 0);
      end
      check_int("restart_lit_cycles", c1, 12);
      check_int("off_then_rise_write_dark", c2, 0);
      check_int("late_arm_lit_cycles", c3, 8);
      check_int("no_third_pulse", c4, 0);

      // randomized writes against the model, with one reset mid-run
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if (c == 400) do_reset();
         en = ($urandom_range(0, 9) != 0);
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 4), $urandom_range(0, 3),
               $urandom_range(0, 15));
         step("random", a);
      end
      drive(0, 0, 0, 15);
      en = 1'b1;

`ifdef LED_DRV_PWM_EN
      do_reset();
      c1 = 0;
      c2 = 0;
      for (int e = 1; e <= 74; e++) begin
         if (e == 1)       drive(1, 0, 1, 4);
         else if (e == 41) drive(1, 0, 1, 0);
         else              drive(0, 0, 0, 15);
         step("pwm", a);
         if (e >= 9 && e <= 40 && a[N_CH]) c1++;
         if (e >= 42 && a[N_CH])           c2++;
      end
      check_int("pwm_duty4_lit", c1, 8);
      check_int("pwm_duty0_lit", c2, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
